complex_div: RTL and testbench
==============================

# complex_div

Sequential signed complex divider: computes (a1 + b1 i) / (a2 + b2 i) on 8-bit signed operands, producing an 8-bit signed real and imaginary quotient. It is the inverse-operation companion of the pipelined complex multiplier and sits in the same arithmetic datapath. It uses a start/done handshake and one shared iteration controller driving two parallel restoring dividers, one real and one imaginary.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- a1  in  8 signed  dividend real part.
- b1  in  8 signed  dividend imaginary part.
- a2  in  8 signed  divisor real part.
- b2  in  8 signed  divisor imaginary part.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results and flags valid.
- res_re  out  8 signed  real quotient, held until the next done.
- res_im  out  8 signed  imaginary quotient, held until the next done.
- div_zero  out  1  divisor was 0+0i; valid with done, held.
- ovf  out  1  either quotient saturated; valid with done, held.

## Operation
- Math: num_re = a1*a2 + b1*b2 and num_im = b1*a2 − a1*b2, both 17-bit signed. den = a2² + b2², 16-bit unsigned, maximum 32768.
- Quotient:
  - Each quotient is num/den, truncated toward zero.
  - The divide runs on magnitudes. The sign is restored afterwards, negative when num < 0.
  - Each result is saturated to [−128, 127]; ovf is set if either part saturates.
  - The magnitude can reach 181, so saturation is reachable.
- Division by zero: when den = 0, res_re = 0, res_im = 0, div_zero = 1 and ovf = 0.
- FSM states:
  - IDLE: when start = 1, capture a1, b1, a2 and b2; busy goes high; go to PREP.
  - PREP (1 cycle): register num_re, num_im and den as magnitudes plus sign bits; load iteration counter = 16; go to DIV.
  - DIV (16 cycles): one restoring shift-subtract step per cycle on both dividers; decrement the counter; go to FIN after the 16th step.
  - FIN (1 cycle): apply sign, saturation and the zero check; register the outputs; pulse done; deassert busy; go to IDLE.
- start in any state other than IDLE is ignored; inputs are not re-sampled.
- Inputs need to be valid only in the cycle start is sampled.

## Timing
- Latency: done is high in the cycle after the 18th rising edge following the edge that sampled start. Edge 0 is the capture edge; the FIN update happens on edge 18.
- busy rises after edge 0 and falls after edge 18, in the same cycle done rises.
- Back-to-back operation: start may be asserted in the cycle where done = 1, since the FSM is then in IDLE. The new operation begins on the next edge, so throughput is 1 result per 19 cycles.
- Reset (asynchronous, at any time, including mid-DIV):
  - State → IDLE; busy = 0, done = 0.
  - res_re = 0, res_im = 0, div_zero = 0, ovf = 0; internal registers cleared.
  - The operation in flight is discarded with no done pulse.
  - The first start after rst deasserts is handled normally.
- Outputs never change except on edge 18 (FIN) or reset.

## Test plan
- (3+4i)/(1+2i) -> res_re = 2, res_im = 0, ovf = 0, div_zero = 0, done exactly 18 edges after start.
- (10+0i)/(0+1i) -> res_re = 0, res_im = −10; (−7+0i)/(2+0i) -> res_re = −3 (truncated toward zero), res_im = 0.
- (5+5i)/(0+0i) -> res_re = 0, res_im = 0, div_zero = 1, ovf = 0; the next operation (4+0i)/(2+0i) -> div_zero = 0, res_re = 2.
- (−128+0i)/(−1+0i) -> res_re = 127, res_im = 0, ovf = 1; (−128−128i)/(1+0i) -> res_re = −128, res_im = −128, ovf = 0.
- Pulse start again during DIV with different operands -> ignored, first result unchanged. Assert start in the done cycle -> second done arrives 19 cycles after the first.
- Assert rst at edge 8 of an operation -> busy, done, outputs and flags go to 0 immediately, no done pulse. After release, (6+8i)/(3+4i) -> res_re = 2, res_im = 0.

Source files
------------

// File: rtl/complex_div.sv
// -----------------------------------------------------------------------------
// complex_div
//
// Sequential signed complex divider: (a1 + b1 i) / (a2 + b2 i) on 8-bit signed
// operands, yielding 8-bit signed real and imaginary quotients truncated toward
// zero and saturated to [-128, 127]. One iteration controller drives two
// restoring dividers (lane 0 = real, lane 1 = imaginary) that share the same
// denominator a2^2 + b2^2.
//
// Flow: IDLE (capture) -> PREP (numerators/denominator) -> DIV x16 -> FIN.
// done pulses in the cycle after the FIN edge, which is 18 edges after the
// edge that sampled start.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request pulse, only sampled in IDLE
//   a1, b1    dividend real / imaginary (signed 8)
//   a2, b2    divisor real / imaginary (signed 8)
//   busy      high while an operation is in flight
//   done      one-cycle pulse, results and flags valid
//   res_re    real quotient (signed 8), held until the next done
//   res_im    imaginary quotient (signed 8), held until the next done
//   div_zero  divisor was 0+0i (held)
//   ovf       either quotient saturated (held)
// -----------------------------------------------------------------------------
module complex_div (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [7:0] a1,
    input  logic signed [7:0] b1,
    input  logic signed [7:0] a2,
    input  logic signed [7:0] b2,
    output logic              busy,
    output logic              done,
    output logic signed [7:0] res_re,
    output logic signed [7:0] res_im,
    output logic              div_zero,
    output logic              ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [7:0]       a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
    logic [15:0]      den_q, den_d;
    logic [1:0][15:0] dvd_q, dvd_d;    // dividend magnitude, becomes quotient
    logic [1:0][15:0] rem_q, rem_d;    // partial remainder, always < den
    logic [1:0]       neg_q, neg_d;    // numerator sign per lane
    logic [7:0]       res_re_q, res_re_d, res_im_q, res_im_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    // Full-precision products from the captured operands (8x8 -> 16 signed).
    logic signed [15:0] p_a1a2, p_b1b2, p_b1a2, p_a1b2, p_a2a2, p_b2b2;
    assign p_a1a2 = $signed({{8{a1_q[7]}}, a1_q}) * $signed({{8{a2_q[7]}}, a2_q});
    assign p_b1b2 = $signed({{8{b1_q[7]}}, b1_q}) * $signed({{8{b2_q[7]}}, b2_q});
    assign p_b1a2 = $signed({{8{b1_q[7]}}, b1_q}) * $signed({{8{a2_q[7]}}, a2_q});
    assign p_a1b2 = $signed({{8{a1_q[7]}}, a1_q}) * $signed({{8{b2_q[7]}}, b2_q});
    assign p_a2a2 = $signed({{8{a2_q[7]}}, a2_q}) * $signed({{8{a2_q[7]}}, a2_q});
    assign p_b2b2 = $signed({{8{b2_q[7]}}, b2_q}) * $signed({{8{b2_q[7]}}, b2_q});

    // 17-bit two's complement numerators; bit arithmetic on sign-extended values.
    logic [1:0][16:0] num;
    logic [15:0]      den;
    assign num[0] = {p_a1a2[15], p_a1a2} + {p_b1b2[15], p_b1b2};
    assign num[1] = {p_b1a2[15], p_b1a2} - {p_a1b2[15], p_a1b2};
    // Each square is at most 16384, so the sum (max 32768) fits 16 unsigned bits.
    assign den = $unsigned(p_a2a2) + $unsigned(p_b2b2);

    logic [1:0][15:0] mag;
    logic [1:0][15:0] step_dvd;
    logic [1:0][15:0] step_rem;
    logic [1:0][7:0]  sat_res;
    logic [1:0]       sat_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [16:0] rem_sh;
            logic        ge;

            // |num| in 16 bits; -32768 maps to 0x8000 = 32768, which is exact.
            assign mag[gi] = num[gi][16] ? (~num[gi][15:0] + 16'd1) : num[gi][15:0];

            // One restoring step: shift in the next dividend bit, try to subtract.
            assign rem_sh       = {rem_q[gi], dvd_q[gi][15]};
            assign ge           = (rem_sh >= {1'b0, den_q});
            assign step_rem[gi] = ge ? 16'(rem_sh - {1'b0, den_q}) : rem_sh[15:0];
            assign step_dvd[gi] = {dvd_q[gi][14:0], ge};

            // Sign restore with saturation; a negative magnitude of exactly 128
            // is representable, anything larger clips.
            always_comb begin
                sat_res[gi] = 8'd0;
                sat_ovf[gi] = 1'b0;
                if (neg_q[gi]) begin
                    if (dvd_q[gi] > 16'd128) begin
                        sat_res[gi] = 8'h80;
                        sat_ovf[gi] = 1'b1;
                    end else begin
                        sat_res[gi] = ~dvd_q[gi][7:0] + 8'd1;
                    end
                end else begin
                    if (dvd_q[gi] > 16'd127) begin
                        sat_res[gi] = 8'h7f;
                        sat_ovf[gi] = 1'b1;
                    end else begin
                        sat_res[gi] = dvd_q[gi][7:0];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        a1_d       = a1_q;
        b1_d       = b1_q;
        a2_d       = a2_q;
        b2_d       = b2_q;
        den_d      = den_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        neg_d      = neg_q;
        res_re_d   = res_re_q;
        res_im_d   = res_im_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a1_d    = a1;
                    b1_d    = b1;
                    a2_d    = a2;
                    b2_d    = b2;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                den_d   = den;
                dvd_d   = mag;
                rem_d   = '0;
                neg_d   = {num[1][16], num[0][16]};
                cnt_d   = 5'd16;
                state_d = S_DIV;
            end
            S_DIV: begin
                dvd_d = step_dvd;
                rem_d = step_rem;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (den_q == 16'd0) begin
                    res_re_d   = 8'd0;
                    res_im_d   = 8'd0;
                    div_zero_d = 1'b1;
                    ovf_d      = 1'b0;
                end else begin
                    res_re_d   = sat_res[0];
                    res_im_d   = sat_res[1];
                    div_zero_d = 1'b0;
                    ovf_d      = |sat_ovf;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 5'd0;
            a1_q       <= 8'd0;
            b1_q       <= 8'd0;
            a2_q       <= 8'd0;
            b2_q       <= 8'd0;
            den_q      <= 16'd0;
            dvd_q      <= '0;
            rem_q      <= '0;
            neg_q      <= 2'b00;
            res_re_q   <= 8'd0;
            res_im_q   <= 8'd0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            a2_q       <= a2_d;
            b2_q       <= b2_d;
            den_q      <= den_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            neg_q      <= neg_d;
            res_re_q   <= res_re_d;
            res_im_q   <= res_im_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_re   = res_re_q;
    assign res_im   = res_im_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_complex_div.sv
// -----------------------------------------------------------------------------
// tb_complex_div
//
// Directed bench for complex_div. Each launched operation pushes its expected
// result onto a scoreboard queue; the entry is popped and compared when done
// pulses. Also checks latency, back-to-back spacing, ignored mid-run start,
// and asynchronous reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_complex_div;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [7:0] a1, b1, a2, b2;
    logic              busy, done;
    logic signed [7:0] res_re, res_im;
    logic              div_zero, ovf;

    complex_div dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a1       (a1),
        .b1       (b1),
        .a2       (a2),
        .b2       (b2),
        .busy     (busy),
        .done     (done),
        .res_re   (res_re),
        .res_im   (res_im),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int dz;
        int ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   done_edge = 0;
    int   prev_done_edge = 0;
    bit   saw_done;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive operands with start, consume the capture edge, then scramble the
    // operand inputs so any late re-sampling would corrupt the result.
    task automatic launch(input int x1, input int y1, input int x2, input int y2,
                          input int er, input int ei, input int ez, input int eo);
        exp_t e;
        a1 = 8'(x1);
        b1 = 8'(y1);
        a2 = 8'(x2);
        b2 = 8'(y2);
        start = 1'b1;
        e.re = er;
        e.im = ei;
        e.dz = ez;
        e.ov = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a1 = 8'($urandom);
        b1 = 8'($urandom);
        a2 = 8'($urandom);
        b2 = 8'($urandom);
        chk("busy_rise", int'(busy), 1);
    endtask

    // Count edges after the capture edge until done; optionally pulse start
    // with junk operands right before edge pulse_at+1 (mid-DIV).
    task automatic wait_done(input string tag, input int pulse_at);
        int   n;
        bit   seen;
        exp_t e;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (n == pulse_at) begin
                start = 1'b1;
                a1 = 8'sd77;
                b1 = -8'sd33;
                a2 = 8'sd1;
                b2 = 8'sd0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        prev_done_edge = done_edge;
        done_edge = edge_cnt;
        chk({tag, "_latency"}, n, 18);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_re"}, int'(res_re), e.re);
            chk({tag, "_im"}, int'(res_im), e.im);
            chk({tag, "_dz"}, int'(div_zero), e.dz);
            chk({tag, "_ovf"}, int'(ovf), e.ov);
            chk({tag, "_busy_low"}, int'(busy), 0);
        end
        $display("op %s: re=%0d im=%0d dz=%0d ovf=%0d latency=%0d",
                 tag, res_re, res_im, div_zero, ovf, n);
    endtask

    initial begin
        exp_t dropped;
        rst = 1'b1;
        start = 1'b0;
        a1 = '0;
        b1 = '0;
        a2 = '0;
        b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_re", int'(res_re), 0);
        chk("rst_im", int'(res_im), 0);
        chk("rst_dz", int'(div_zero), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic divide and latency.
        @(negedge clk);
        launch(3, 4, 1, 2, 2, 0, 0, 0);
        wait_done("op1", 0);

        // Start pulsed mid-DIV with other operands must be ignored.
        @(negedge clk);
        launch(10, 0, 0, 1, 0, -10, 0, 0);
        wait_done("op2_ign", 5);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ign_idle_busy", int'(busy), 0);
            chk("ign_idle_done", int'(done), 0);
        end

        // Back-to-back chain: each new start issued in the done cycle.
        @(negedge clk);
        launch(-7, 0, 2, 0, -3, 0, 0, 0);
        wait_done("op3_trunc", 0);
        launch(5, 5, 0, 0, 0, 0, 1, 0);
        wait_done("op4_dz", 0);
        chk("b2b_spacing", done_edge - prev_done_edge, 19);
        launch(4, 0, 2, 0, 2, 0, 0, 0);
        wait_done("op5_after_dz", 0);
        launch(-128, 0, -1, 0, 127, 0, 0, 1);
        wait_done("op6_sat", 0);
        launch(-128, -128, 1, 0, -128, -128, 0, 0);
        wait_done("op7_neg128", 0);
        launch(-128, -128, -1, -1, 127, 0, 0, 1);
        wait_done("op8_sat_den2", 0);
        launch(100, -50, 3, 4, 4, -22, 0, 0);
        wait_done("op9_mixed", 0);

        // Asynchronous reset after edge 8 of an operation.
        @(negedge clk);
        launch(1, 1, 1, 0, 1, 1, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_re", int'(res_re), 0);
        chk("mid_rst_im", int'(res_im), 0);
        chk("mid_rst_dz", int'(div_zero), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        dropped = sb.pop_front();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", int'(saw_done), 0);

        @(negedge clk);
        launch(6, 8, 3, 4, 2, 0, 0, 0);
        wait_done("op10_after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
